// File: rtl/rv32_control.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback for the datapath.
// Latency: 3 cycles (FETCH, DECODE, EXEC) before WB/MEM/BTGT; FETCH and MEM add one cycle per mem_ready=0.
// Backpressure: memory stalls FETCH and MEM via mem_ready; no other stall sources.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   instr                 instruction held in the datapath instruction register
//   alu_flags             [0] zero, [1] signed less, [2] carry ([4:3] unused)
//   mem_ready             memory finishes the outstanding request this cycle
//   mem_req/mem_we/...    memory request, store flag, access size, address select
//   *_we                  datapath register write enables
//   rst_nar               clears datapath non-architectural registers
//   alu_*                 ALU operation, arithmetic mode, carry-in
//   flagout/flagsel       write compare flag to rd, unsigned (1) or signed (0)
//   a_sel/b_sel/pc_sel    operand and PC-source selects
//   wd_sel/format         register write-data select, immediate format
//   state                 rs1 read port addressed from instr[19:15]
//   halt                  controller stopped on an illegal instruction
module rv32_control #(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic [4:0]  alu_flags,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [2:0]  mem_size,
  output logic        instr_we,
  output logic        rf_we,
  output logic        pc_we,
  output logic        rs1_we,
  output logic        rs2_we,
  output logic        alu_we,
  output logic        prev_pc_we,
  output logic        rst_nar,
  output logic        alu_arith,
  output logic        alu_cin,
  output logic [3:0]  alu_sel,
  output logic        flagout,
  output logic        flagsel,
  output logic        mem_ad_sel,
  output logic [1:0]  a_sel,
  output logic [1:0]  b_sel,
  output logic [1:0]  pc_sel,
  output logic [2:0]  wd_sel,
  output logic [2:0]  format,
  output logic        state,
  output logic        halt
);

  typedef enum logic [2:0] {
    S_INIT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BTGT, S_HALT
  } st_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam logic [2:0] FMT_I = 3'd0;
  localparam logic [2:0] FMT_S = 3'd1;
  localparam logic [2:0] FMT_B = 3'd2;
  localparam logic [2:0] FMT_U = 3'd3;
  localparam logic [2:0] FMT_J = 3'd4;

  st_t  cur_st, nxt_st;
  logic started;   // low from reset until the first clock edge after release
  logic taken_q;
  logic taken_d;
  logic rf_we_raw;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       rd_nz;
  logic is_lui, is_auipc, is_jal, is_jalr, is_branch;
  logic is_load, is_store, is_opimm, is_op, is_fence;
  logic is_legal, is_cmp;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign rd_nz  = |instr[11:7];

  assign is_lui    = (opcode == OP_LUI);
  assign is_auipc  = (opcode == OP_AUIPC);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_opimm  = (opcode == OP_IMM);
  assign is_op     = (opcode == OP_REG);
  assign is_fence  = (opcode == OP_FENCE);

  // SYSTEM (ECALL/EBREAK and CSR forms) is deliberately absent: no CSR
  // file exists, so every SYSTEM encoding is handled as illegal.
  assign is_legal = is_lui | is_auipc | is_jal | is_jalr | is_branch |
                    is_load | is_store | is_opimm | is_op | is_fence;

  // SLT/SLTU/SLTI/SLTIU share funct3 = 01x
  assign is_cmp = (is_op | is_opimm) && (funct3[2:1] == 2'b01);

  // Branch outcome from the rs1-rs2 subtraction; carry set means no borrow.
  always_comb begin
    taken_d = 1'b0;
    case (funct3)
      3'b000:  taken_d =  alu_flags[0];
      3'b001:  taken_d = ~alu_flags[0];
      3'b100:  taken_d =  alu_flags[1];
      3'b101:  taken_d = ~alu_flags[1];
      3'b110:  taken_d = ~alu_flags[2];
      3'b111:  taken_d =  alu_flags[2];
      default: taken_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_st  <= S_INIT;
      started <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      cur_st  <= nxt_st;
      started <= 1'b1;
      if (cur_st == S_EXEC) taken_q <= taken_d;
    end
  end

  always_comb begin
    nxt_st     = cur_st;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_size   = 3'b000;
    instr_we   = 1'b0;
    rf_we_raw  = 1'b0;
    pc_we      = 1'b0;
    rs1_we     = 1'b0;
    rs2_we     = 1'b0;
    alu_we     = 1'b0;
    prev_pc_we = 1'b0;
    rst_nar    = 1'b0;
    alu_arith  = 1'b0;
    alu_cin    = 1'b0;
    alu_sel    = 4'b0000;
    flagout    = 1'b0;
    flagsel    = 1'b0;
    mem_ad_sel = 1'b0;
    a_sel      = 2'b00;
    b_sel      = 2'b00;
    pc_sel     = 2'b00;
    wd_sel     = 3'b000;
    format     = FMT_I;
    state      = 1'b0;
    halt       = 1'b0;

    if (!started) begin
      // Held in reset (or the edge that releases it): only clear the datapath.
      rst_nar = 1'b1;
      nxt_st  = S_INIT;
    end else begin
      case (cur_st)
        S_INIT: begin
          rst_nar = 1'b1;
          pc_sel  = 2'b01;
          pc_we   = 1'b1;
          nxt_st  = S_FETCH;
        end

        S_FETCH: begin
          mem_req    = 1'b1;
          mem_ad_sel = 1'b0;
          mem_size   = 3'b010;
          if (mem_ready) begin
            instr_we   = 1'b1;
            prev_pc_we = 1'b1;
            nxt_st     = S_DECODE;
          end
        end

        S_DECODE: begin
          state  = 1'b1;
          rs1_we = 1'b1;
          rs2_we = 1'b1;
          a_sel  = 2'b01;   // PC
          b_sel  = 2'b10;   // constant 4
          pc_sel = 2'b00;
          pc_we  = 1'b1;
          if (is_legal)             nxt_st = S_EXEC;
          else if (HALT_ON_ILLEGAL) nxt_st = S_HALT;
          else                      nxt_st = S_FETCH;
        end

        S_EXEC: begin
          alu_we = 1'b1;
          nxt_st = S_WB;
          if (is_op || is_opimm) begin
            a_sel = 2'b00;
            b_sel = is_opimm ? 2'b01 : 2'b00;
            if (is_cmp) begin
              // Flag lands in rd straight from the subtractor; no WB cycle.
              alu_sel   = 4'b1000;
              alu_arith = 1'b1;
              alu_cin   = 1'b1;
              rf_we_raw = 1'b1;
              flagout   = 1'b1;
              flagsel   = funct3[0];
              nxt_st    = S_FETCH;
            end else if (is_op) begin
              alu_sel   = {instr[30], funct3};
              alu_arith = (funct3 == 3'b000);
              alu_cin   = (funct3 == 3'b000) && instr[30];
            end else begin
              // instr[30] is only an opcode bit for SRAI; elsewhere it is immediate.
              alu_sel   = {(funct3 == 3'b101) && instr[30], funct3};
              alu_arith = (funct3 == 3'b000);
            end
          end else if (is_load || is_store || is_jalr) begin
            a_sel     = 2'b00;
            b_sel     = 2'b01;
            format    = is_store ? FMT_S : FMT_I;
            alu_arith = 1'b1;
            if (!is_jalr) nxt_st = S_MEM;
          end else if (is_lui || is_auipc) begin
            a_sel     = is_lui ? 2'b11 : 2'b10;
            b_sel     = 2'b01;
            format    = FMT_U;
            alu_arith = 1'b1;
          end else if (is_jal) begin
            a_sel     = 2'b10;
            b_sel     = 2'b01;
            format    = FMT_J;
            alu_arith = 1'b1;
          end else if (is_branch) begin
            alu_sel   = 4'b1000;
            alu_arith = 1'b1;
            alu_cin   = 1'b1;
            nxt_st    = S_BTGT;
          end else begin
            // FENCE: no ordering work needed on a single in-order port.
            nxt_st = S_FETCH;
          end
        end

        S_MEM: begin
          mem_req    = 1'b1;
          mem_ad_sel = 1'b1;
          mem_we     = is_store;
          mem_size   = funct3;
          if (mem_ready) begin
            if (is_load) begin
              rf_we_raw = 1'b1;
              wd_sel    = 3'b001;
            end
            nxt_st = S_FETCH;
          end
        end

        S_WB: begin
          rf_we_raw = 1'b1;
          if (is_jal || is_jalr) begin
            // rd captures the PC before this cycle's update, i.e. the link address.
            wd_sel = 3'b011;
            pc_sel = 2'b10;
            pc_we  = 1'b1;
          end else begin
            wd_sel = 3'b010;
          end
          nxt_st = S_FETCH;
        end

        S_BTGT: begin
          a_sel  = 2'b10;
          b_sel  = 2'b01;
          format = FMT_B;
          pc_sel = 2'b00;
          pc_we  = taken_q;
          nxt_st = S_FETCH;
        end

        S_HALT: begin
          halt   = 1'b1;
          nxt_st = S_HALT;
        end

        default: nxt_st = S_INIT;
      endcase
    end
  end

  // x0 is never written, whatever state requested it.
  assign rf_we = rf_we_raw & rd_nz;

  logic unused_bits;
  assign unused_bits = ^{instr[31], instr[29:15], alu_flags[4:3]};

endmodule
